// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode encodings, init patterns and step rules for the LED sequencer
//
// Purpose: shared definitions for led_seq_ctrl and led_key_debounce.
//   mode_e        : 2-bit display mode encoding
//   INIT_*        : pattern loaded when a mode is entered
//   next_mode()   : mode advance on a button press, 3 wraps to 0
//   init_pattern(): initial LED pattern for a mode
//   next_pattern(): pattern after one step in a mode
// Ports: none (package).

package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_WALK_L = 2'd0,
      MODE_WALK_R = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   localparam logic [3:0] INIT_WALK_L = 4'b0001;
   localparam logic [3:0] INIT_WALK_R = 4'b1000;
   localparam logic [3:0] INIT_BLINK  = 4'b1111;
   localparam logic [3:0] INIT_COUNT  = 4'b0000;

   function automatic mode_e next_mode(input mode_e m);
      mode_e r;
      case (m)
         MODE_WALK_L: r = MODE_WALK_R;
         MODE_WALK_R: r = MODE_BLINK;
         MODE_BLINK:  r = MODE_COUNT;
         default:     r = MODE_WALK_L;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] init_pattern(input mode_e m);
      logic [3:0] r;
      case (m)
         MODE_WALK_L: r = INIT_WALK_L;
         MODE_WALK_R: r = INIT_WALK_R;
         MODE_BLINK:  r = INIT_BLINK;
         default:     r = INIT_COUNT;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] next_pattern(input mode_e m, input logic [3:0] cur);
      logic [3:0] r;
      case (m)
         MODE_WALK_L: r = {cur[2:0], cur[3]};
         MODE_WALK_R: r = {cur[0], cur[3:1]};
         MODE_BLINK:  r = ~cur;
         default:     r = cur + 4'd1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_key_debounce.sv
// rtl/led_key_debounce.sv - push-button synchronizer, debouncer and press pulse
//
// Purpose: brings the raw active-low key into the clk domain through two
// flops, accepts a new level only after it has been stable for DEB_CYCLES
// consecutive cycles, and flags the accepted 1->0 transition as a press.
// Ports:
//   clk_i    in  1  system clock
//   rst_n_i  in  1  asynchronous active-low reset
//   key_n_i  in  1  raw push-button, active-low, asynchronous, bouncy
//   press_o  out 1  one-cycle pulse; the debounced level falls on the
//                   clock edge that ends this cycle

module led_key_debounce
   import led_seq_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic key_n_i,
   output logic press_o
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             key_s_q;
   logic             key_db_q, key_db_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             accept;

   // The synchronized key has differed from the accepted level for
   // DEB_CYCLES consecutive cycles including this one.
   assign accept = (key_s_q != key_db_q) && (cnt_q == DEB_LAST);

   always_comb begin
      key_db_d = key_db_q;
      cnt_d    = '0;
      if (key_s_q != key_db_q) begin
         if (cnt_q == DEB_LAST) begin
            key_db_d = key_s_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Driven only from flops, so there is no path from key_n_i to the LEDs.
   assign press_o = accept & ~key_s_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q  <= 1'b1;
         key_s_q  <= 1'b1;
         key_db_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_n_i;
         key_s_q  <= sync1_q;
         key_db_q <= key_db_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - mode-controlled pattern sequencer for the 4-LED bank
//
// Purpose: a debounced button press cycles through four display modes; the
// pattern of the current mode advances once every STEP_CYCLES clocks unless
// pause is high. A press always reloads the new mode's initial pattern and
// restarts the step interval, even while paused.
// Ports:
//   clk      in  1  system clock, 50 MHz nominal
//   rst_led  in  1  asynchronous active-low reset
//   key_n    in  1  raw push-button, active-low, asynchronous, bouncy
//   pause    in  1  level; 1 freezes the step counter and the pattern
//   led      out 4  LED drive, 1 = on (registered)
//   mode     out 2  current mode (registered)

module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 50_000_000,
   parameter int unsigned DEB_CYCLES  = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_led,
   input  logic       key_n,
   input  logic       pause,
   output logic [3:0] led,
   output logic [1:0] mode
);

   localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

   logic              press;
   mode_e             mode_q;
   logic [3:0]        led_q;
   logic [STEP_W-1:0] step_q;

   led_key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key (
      .clk_i   (clk),
      .rst_n_i (rst_led),
      .key_n_i (key_n),
      .press_o (press)
   );

   // Press has priority over a coinciding step, so a step that lands on
   // the same edge as a press is dropped and the new mode starts clean.
   always_ff @(posedge clk or negedge rst_led) begin
      if (!rst_led) begin
         mode_q <= MODE_WALK_L;
         led_q  <= INIT_WALK_L;
         step_q <= '0;
      end else if (press) begin
         mode_q <= next_mode(mode_q);
         led_q  <= init_pattern(next_mode(mode_q));
         step_q <= '0;
      end else if (!pause) begin
         if (step_q == STEP_LAST) begin
            step_q <= '0;
            led_q  <= next_pattern(mode_q, led_q);
         end else begin
            step_q <= step_q + 1'b1;
         end
      end
   end

   assign led  = led_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl against a behavioural model

module tb_led_seq_ctrl;

   localparam int STEP = 10;
   localparam int DEB  = 4;

   logic       clk     = 1'b0;
   logic       rst_led = 1'b0;
   logic       key_n   = 1'b1;
   logic       pause   = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;

   led_seq_ctrl #(
      .STEP_CYCLES (STEP),
      .DEB_CYCLES  (DEB)
   ) dut (
      .clk     (clk),
      .rst_led (rst_led),
      .key_n   (key_n),
      .pause   (pause),
      .led     (led),
      .mode    (mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic [1:0] mode;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;

   // Reference model: key history since reset, accepted key level, mode,
   // number of steps taken since the mode's init pattern, and unpaused
   // cycles since the last step / mode entry.
   bit   keys[$];
   int   m_edge;
   int   m_last_flip;
   bit   m_db;
   int   m_mode;
   int   m_k;
   int   m_phase;

   function automatic logic [3:0] model_led();
      case (m_mode)
         0:       return 4'(1 << (m_k % 4));
         1:       return 4'(8 >> (m_k % 4));
         2:       return ((m_k % 2) == 0) ? 4'hF : 4'h0;
         default: return 4'(m_k % 16);
      endcase
   endfunction

   function automatic void model_reset();
      keys.delete();
      m_edge      = 0;
      m_last_flip = 0;
      m_db        = 1'b1;
      m_mode      = 0;
      m_k         = 0;
      m_phase     = 0;
   endfunction

   // Key level seen by the debouncer at edge idx: the raw key two edges
   // earlier, or idle-high right after reset.
   function automatic bit sync_key(input int idx);
      return (idx >= 2) ? keys[idx - 2] : 1'b1;
   endfunction

   function automatic void model_edge(input bit kn, input bit p);
      bit accept;
      bit pressed;
      keys.push_back(kn);
      accept = 1'b1;
      for (int j = 0; j < DEB; j++) begin
         if ((m_edge - j) < m_last_flip) accept = 1'b0;
         else if (sync_key(m_edge - j) == m_db) accept = 1'b0;
      end
      pressed = 1'b0;
      if (accept) begin
         m_db        = ~m_db;
         m_last_flip = m_edge + 1;
         pressed     = (m_db == 1'b0);
      end
      if (pressed) begin
         m_mode  = (m_mode + 1) % 4;
         m_k     = 0;
         m_phase = 0;
      end else if (!p) begin
         m_phase = m_phase + 1;
         if (m_phase == STEP) begin
            m_phase = 0;
            m_k     = m_k + 1;
         end
      end
      m_edge = m_edge + 1;
   endfunction

   // Apply inputs for the next edge, queue the expected state after it.
   task automatic tick(input bit kn, input bit p);
      exp_t e;
      key_n = kn;
      pause = p;
      model_edge(kn, p);
      e.cyc  = edge_n + 1;
      e.led  = model_led();
      e.mode = 2'(m_mode);
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic press_key(input int low_cycles, input int high_cycles);
      repeat (low_cycles) tick(1'b0, 1'b0);
      repeat (high_cycles) tick(1'b1, 1'b0);
   endtask

   task automatic check_reset_state(input string name);
      n_checks++;
      if (led !== 4'b0001 || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL %s: got led=%b mode=%0d, expected led=0001 mode=0", name, led, mode);
      end
   endtask

   task automatic do_reset();
      #2;
      key_n   = 1'b1;
      pause   = 1'b0;
      rst_led = 1'b0;
      #1;
      check_reset_state("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst_led = 1'b1;
   endtask

   task automatic wait_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: model condition not reached within bound, got mode=%0d led=%b, expected the target state", name, mode, led);
   endtask

   // Monitor: after every edge compare any expectation due by now.
   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         #2;
         while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
            exp_t e;
            e = sbq.pop_front();
            n_checks++;
            if (e.cyc != edge_n || led !== e.led || mode !== e.mode) begin
               n_fail++;
               $display("FAIL scoreboard cyc %0d (due %0d): got led=%b mode=%0d, expected led=%b mode=%0d",
                        edge_n, e.cyc, led, mode, e.led, e.mode);
            end
         end
      end
   end

   initial begin
      int guard;
      bit ok;

      model_reset();
      #12;
      check_reset_state("reset_state");
      @(posedge clk);
      #1;
      rst_led = 1'b1;

      // Free-running walk-left after reset.
      repeat (45) tick(1'b1, 1'b0);

      // One clean press held 8 cycles, then release.
      press_key(8, 30);

      // Bounce: toggling every 2 cycles never stays stable long enough.
      for (int i = 0; i < 20; i++) tick(((i / 2) % 2) != 0, 1'b0);
      repeat (20) tick(1'b1, 1'b0);

      // Four clean presses: modes 2, 3, 0, 1 after the earlier press.
      repeat (4) press_key(8, 22);

      // Pause at step count 5 with a press in the middle of the pause.
      ok = 1'b0;
      for (guard = 0; guard < 40; guard++) begin
         if (m_phase == 5) begin
            ok = 1'b1;
            break;
         end
         tick(1'b1, 1'b0);
      end
      if (!ok) wait_fail("reach_phase5");
      for (int i = 0; i < 25; i++) tick(!(i >= 3 && i < 11), 1'b1);
      repeat (15) tick(1'b1, 1'b0);

      // Reach mode 3, then time a press onto the terminal-count edge at led=0011.
      for (guard = 0; guard < 6 && m_mode != 3; guard++) press_key(8, 22);
      if (m_mode != 3) wait_fail("reach_mode3");
      ok = 1'b0;
      for (guard = 0; guard < 200; guard++) begin
         if (m_k == 3 && m_phase == 4) begin
            ok = 1'b1;
            break;
         end
         tick(1'b1, 1'b0);
      end
      if (!ok) wait_fail("reach_led0011_phase4");
      press_key(8, 12);

      // Reset pulse in the middle of a step interval.
      repeat (13) tick(1'b1, 1'b0);
      do_reset();
      repeat (45) tick(1'b1, 1'b0);

      // Random key/pause segments.
      for (int s = 0; s < 60; s++) begin
         int len;
         bit kn;
         bit p;
         len = $urandom_range(1, 12);
         kn  = 1'($urandom_range(0, 1));
         p   = ($urandom_range(0, 3) == 0);
         repeat (len) tick(kn, p);
      end
      repeat (20) tick(1'b1, 1'b0);

      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
